sum_sat_buf: RTL and testbench

SUM_SAT_BUF -- requirements
Module: sum_sat_buf

---
 rtl/sum_sat_buf.sv | 95 +++++++++
 tb/tb_sum_sat_buf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sum_sat_buf.sv
// Four-entry first-word-fall-through buffer for adder sums, with optional
// saturation of overflowed samples, drop pulse and overflow sample counter.
module sum_sat_buf #(
    parameter int unsigned SAT_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sumin,
    input  logic        ovfin,
    input  logic        in_vld,
    output logic [15:0] dout,
    output logic        dout_ovf,
    output logic        dout_vld,
    input  logic        dout_rdy,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty,
    output logic        drop,
    output logic [7:0]  ovf_cnt
);

    logic [15:0] mem_q [4];
    logic        mem_ovf_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        drop_q, drop_d;
    logic [7:0]  ovf_cnt_q, ovf_cnt_d;

    logic        push, pop;
    logic [15:0] wdata;

    assign full     = (count_q == 3'd4);
    assign empty    = (count_q == 3'd0);
    assign dout_vld = ~empty;
    assign dout     = mem_q[rd_ptr_q];
    assign dout_ovf = mem_ovf_q[rd_ptr_q];
    assign count    = count_q;
    assign drop     = drop_q;
    assign ovf_cnt  = ovf_cnt_q;

    assign pop  = dout_vld & dout_rdy;
    assign push = in_vld & (~full | pop);

    // sumin[15] is the wrapped sign, so a set bit means the true sum was positive.
    always_comb begin
        wdata = sumin;
        if (ovfin && (SAT_EN != 0)) begin
            wdata = sumin[15] ? 16'h7FFF : 16'h8000;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_cnt_d = ovf_cnt_q;
        drop_d    = in_vld & full & ~pop;
        if (push) wr_ptr_d = wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (push && ovfin && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
            ovf_cnt_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i]     <= '0;
                mem_ovf_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            ovf_cnt_q <= ovf_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q]     <= wdata;
                mem_ovf_q[wr_ptr_q] <= ovfin;
            end
        end
    end

endmodule

// File: tb/tb_sum_sat_buf.sv
// Scoreboard bench for sum_sat_buf: stimulus queues expected head entries,
// a negedge monitor checks every accepted pop against them.
module tb_sum_sat_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sumin = '0;
    logic        ovfin = 1'b0;
    logic        in_vld = 1'b0;
    logic        dout_rdy = 1'b0;

    logic [15:0] dout, dout0;
    logic        dout_ovf, dout_ovf0;
    logic        dout_vld, dout_vld0;
    logic [2:0]  count, count0;
    logic        full, full0, empty, empty0, drop, drop0;
    logic [7:0]  ovf_cnt, ovf_cnt0;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb [$];

    always #5 clk = ~clk;

    sum_sat_buf #(.SAT_EN(1)) dut (
        .clk(clk), .reset(reset), .sumin(sumin), .ovfin(ovfin), .in_vld(in_vld),
        .dout(dout), .dout_ovf(dout_ovf), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .count(count), .full(full), .empty(empty), .drop(drop), .ovf_cnt(ovf_cnt)
    );

    sum_sat_buf #(.SAT_EN(0)) dut0 (
        .clk(clk), .reset(reset), .sumin(sumin), .ovfin(ovfin), .in_vld(in_vld),
        .dout(dout0), .dout_ovf(dout_ovf0), .dout_vld(dout_vld0), .dout_rdy(dout_rdy),
        .count(count0), .full(full0), .empty(empty0), .drop(drop0), .ovf_cnt(ovf_cnt0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge when vld & rdy are high here.
    always @(negedge clk) begin
        if (reset && dout_vld && dout_rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", {dout_ovf, dout});
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                if ({dout_ovf, dout} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", {dout_ovf, dout}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] d, input logic o,
                         input logic [15:0] expd, input bit accept);
        in_vld = 1'b1;
        sumin  = d;
        ovfin  = o;
        if (accept) sb.push_back({o, expd});
        step();
        in_vld = 1'b0;
        ovfin  = 1'b0;
    endtask

    task automatic drain(input int n);
        dout_rdy = 1'b1;
        for (int i = 0; i < n; i++) step();
        dout_rdy = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_dout", dout, 16'h0);
        check("rst_ovf", dout_ovf, 1'b0);
        check("rst_vld", dout_vld, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        push1(16'h1234, 1'b0, 16'h1234, 1);
        check("basic_dout", dout, 16'h1234);
        check("basic_vld", dout_vld, 1'b1);
        check("basic_count", count, 3'd1);
        drain(1);
        check("basic_empty", empty, 1'b1);

        push1(16'h8001, 1'b1, 16'h7FFF, 1);
        check("sat_pos_dout", dout, 16'h7FFF);
        check("sat_pos_ovf", dout_ovf, 1'b1);
        check("nosat_dout", dout0, 16'h8001);
        check("nosat_ovf", dout_ovf0, 1'b1);
        push1(16'h7FFE, 1'b1, 16'h8000, 1);
        check("sat_ovf_cnt", ovf_cnt, 8'd2);
        drain(1);
        check("sat_neg_dout", dout, 16'h8000);
        drain(1);
        check("sat_empty", empty, 1'b1);

        for (int i = 1; i <= 4; i++) push1(16'(i), 1'b0, 16'(i), 1);
        check("full_flag", full, 1'b1);
        check("full_count", count, 3'd4);
        push1(16'h0005, 1'b1, 16'h0, 0);
        check("drop_pulse", drop, 1'b1);
        check("drop_count", count, 3'd4);
        check("drop_ovf_cnt", ovf_cnt, 8'd2);
        check("drop_head", dout, 16'h0001);
        step();
        check("drop_once", drop, 1'b0);
        drain(4);
        check("drain_empty", empty, 1'b1);

        for (int i = 0; i < 4; i++) push1(16'h0011 + 16'(i), 1'b0, 16'h0011 + 16'(i), 1);
        dout_rdy = 1'b1;
        push1(16'h0009, 1'b0, 16'h0009, 1);
        check("fullpop_count", count, 3'd4);
        check("fullpop_nodrop", drop, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("rdy_empty_count", count, 3'd0);
        check("rdy_empty_vld", dout_vld, 1'b0);
        dout_rdy = 1'b0;

        for (int i = 0; i < 3; i++) push1(16'h0100, 1'b1, 16'h8000, 1);
        drain(3);
        push1(16'hF000, 1'b1, 16'h7FFF, 1);
        push1(16'h0200, 1'b1, 16'h8000, 1);
        push1(16'h0300, 1'b0, 16'h0300, 1);
        check("pre_rst_count", count, 3'd3);
        check("pre_rst_ovf_cnt", ovf_cnt, 8'd7);
        #2 reset = 1'b0;
        #1;
        check("midrst_count", count, 3'd0);
        check("midrst_ovf_cnt", ovf_cnt, 8'd0);
        check("midrst_vld", dout_vld, 1'b0);
        check("midrst_dout", dout, 16'h0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        step();
        push1(16'hABCD, 1'b0, 16'hABCD, 1);
        check("post_rst_count", count, 3'd1);
        check("post_rst_dout", dout, 16'hABCD);
        drain(1);
        check("post_rst_empty", empty, 1'b1);

        dout_rdy = 1'b1;
        in_vld   = 1'b1;
        sumin    = 16'h0001;
        ovfin    = 1'b1;
        for (int i = 0; i < 260; i++) begin
            sb.push_back({1'b1, 16'h8000});
            step();
        end
        in_vld = 1'b0;
        ovfin  = 1'b0;
        check("ovf_cnt_sat", ovf_cnt, 8'd255);
        step();
        dout_rdy = 1'b0;
        check("final_empty", empty, 1'b1);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
